sparse_merge_ctrl: RTL and testbench

Sequencer that merges two sorted sparse vectors, each a stream of (index, value) beats with strictly increasing indices, into the pair-wise compare-and-swap/accumulate pipeline. Each enabled cycle it decides which stream heads to pop and presents them on the CAS input slots. Equal indices are issued together so the pipeline sums them. After the final beat it flushes the pipeline depth and pulses `done`. It also owns the pipeline clock-enable, driving it low when downstream stalls.

---
 rtl/sparse_merge_ctrl.sv | 159 +++++++++++++++
 tb/tb_sparse_merge_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_merge_ctrl.sv
// Sparse-vector merge sequencer feeding a CAS/accumulate pipeline.
// Optional SPMERGE_STATS_EN builds the issue/match statistics counters.
module sparse_merge_ctrl #(
    parameter int ADDRW     = 10,
    parameter int WL        = 32,
    parameter int PIPEDEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [ADDRW-1:0] a_index,
    input  logic [WL-1:0]    a_value,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [ADDRW-1:0] b_index,
    input  logic [WL-1:0]    b_value,
    input  logic             b_last,
    input  logic             out_stall,
    output logic             cas_ena,
    output logic             cas_valid1,
    output logic             cas_valid2,
    output logic [ADDRW-1:0] cas_index1,
    output logic [ADDRW-1:0] cas_index2,
    output logic [WL-1:0]    cas_value1,
    output logic [WL-1:0]    cas_value2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      issue_cnt,
    output logic [15:0]      match_cnt
);
    localparam int CW = $clog2(PIPEDEPTH + 1);

    typedef enum logic [1:0] {IDLE, MERGE, FLUSH} state_t;

    state_t state, state_nxt;

    logic a_done, b_done, a_seen, b_seen;
    logic [ADDRW-1:0] a_prev, b_prev;
    logic [CW-1:0] fcnt;
    logic adv, a_pop, b_pop, fin, flush_end, go;

    assign cas_ena = ~out_stall;
    assign busy    = (state != IDLE);
    assign adv     = (state == MERGE) & ~out_stall;
    assign go      = (state == IDLE) & start & ~out_stall;

    // Readiness never looks at its own valid: the lower index wins.
    assign a_ready = adv & ~a_done & (b_done | (b_valid & (a_index <= b_index)));
    assign b_ready = adv & ~b_done & (a_done | (a_valid & (b_index <= a_index)));
    assign a_pop   = a_ready & a_valid;
    assign b_pop   = b_ready & b_valid;

    assign fin = (a_done | (a_pop & a_last))
               & (b_done | (b_pop & b_last))
               & (a_pop | b_pop);
    assign flush_end = (state == FLUSH) & ~out_stall
                     & (fcnt == CW'(PIPEDEPTH - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (go) state_nxt = MERGE;
            MERGE:   if (fin) state_nxt = FLUSH;
            FLUSH:   if (flush_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            a_seen <= 1'b0;
            b_seen <= 1'b0;
            a_prev <= '0;
            b_prev <= '0;
            err    <= 1'b0;
            fcnt   <= '0;
            done   <= 1'b0;
        end else begin
            done <= flush_end;
            if (go) begin
                a_done <= 1'b0;
                b_done <= 1'b0;
                a_seen <= 1'b0;
                b_seen <= 1'b0;
                err    <= 1'b0;
                fcnt   <= '0;
            end else begin
                if (a_pop) begin
                    a_done <= a_last;
                    a_seen <= 1'b1;
                    a_prev <= a_index;
                    if (a_seen && (a_index <= a_prev)) err <= 1'b1;
                end
                if (b_pop) begin
                    b_done <= b_last;
                    b_seen <= 1'b1;
                    b_prev <= b_index;
                    if (b_seen && (b_index <= b_prev)) err <= 1'b1;
                end
                if ((state == FLUSH) && !out_stall) fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cas_valid1 <= 1'b0;
            cas_valid2 <= 1'b0;
            cas_index1 <= '0;
            cas_index2 <= '0;
            cas_value1 <= '0;
            cas_value2 <= '0;
        end else if (!out_stall) begin
            cas_valid1 <= a_pop | b_pop;
            cas_valid2 <= a_pop & b_pop;
            if (a_pop) begin
                cas_index1 <= a_index;
                cas_value1 <= a_value;
            end else if (b_pop) begin
                cas_index1 <= b_index;
                cas_value1 <= b_value;
            end
            if (a_pop && b_pop) begin
                cas_index2 <= b_index;
                cas_value2 <= b_value;
            end
        end
    end

`ifdef SPMERGE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            match_cnt <= '0;
        end else if (go) begin
            issue_cnt <= '0;
            match_cnt <= '0;
        end else if (!out_stall) begin
            if (a_pop | b_pop) issue_cnt <= issue_cnt + 16'd1;
            if (a_pop & b_pop) match_cnt <= match_cnt + 16'd1;
        end
    end
`else
    assign issue_cnt = '0;
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_sparse_merge_ctrl.sv
// Randomised self-checking bench for sparse_merge_ctrl against a list-merge model.
module tb_sparse_merge_ctrl;
    localparam int ADDRW = 10;
    localparam int WL    = 32;
    localparam int PD    = 5;

    logic clk = 1'b0;
    logic rst, start, out_stall;
    logic a_valid, a_ready, a_last, b_valid, b_ready, b_last;
    logic [ADDRW-1:0] a_index, b_index, cas_index1, cas_index2;
    logic [WL-1:0] a_value, b_value, cas_value1, cas_value2;
    logic cas_ena, cas_valid1, cas_valid2, busy, done, err;
    logic [15:0] issue_cnt, match_cnt;

    int checks = 0;
    int errors = 0;

    int          a_idx[$];
    int          b_idx[$];
    logic [31:0] a_val[$];
    logic [31:0] b_val[$];

    typedef struct {
        int          i1;
        logic [31:0] v1;
        bit          two;
        int          i2;
        logic [31:0] v2;
    } iss_t;
    iss_t exp_q[$];
    int   exp_pairs;

    sparse_merge_ctrl #(.ADDRW(ADDRW), .WL(WL), .PIPEDEPTH(PD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_valid(a_valid), .a_ready(a_ready), .a_index(a_index),
        .a_value(a_value), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_index(b_index),
        .b_value(b_value), .b_last(b_last),
        .out_stall(out_stall), .cas_ena(cas_ena),
        .cas_valid1(cas_valid1), .cas_valid2(cas_valid2),
        .cas_index1(cas_index1), .cas_index2(cas_index2),
        .cas_value1(cas_value1), .cas_value2(cas_value2),
        .busy(busy), .done(done), .err(err),
        .issue_cnt(issue_cnt), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Plain two-pointer merge of the sorted lists: equal heads go out together.
    task automatic build_expected();
        int i = 0;
        int j = 0;
        iss_t e;
        exp_q.delete();
        exp_pairs = 0;
        while (i < a_idx.size() || j < b_idx.size()) begin
            e = '{0, 0, 1'b0, 0, 0};
            if (j >= b_idx.size() || (i < a_idx.size() && a_idx[i] < b_idx[j])) begin
                e.i1 = a_idx[i]; e.v1 = a_val[i]; i++;
            end else if (i >= a_idx.size() || b_idx[j] < a_idx[i]) begin
                e.i1 = b_idx[j]; e.v1 = b_val[j]; j++;
            end else begin
                e.i1 = a_idx[i]; e.v1 = a_val[i];
                e.i2 = b_idx[j]; e.v2 = b_val[j]; e.two = 1'b1;
                i++; j++; exp_pairs++;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic gen_streams(input int range);
        a_idx.delete(); b_idx.delete(); a_val.delete(); b_val.delete();
        for (int x = 0; x < range; x++) begin
            if ($urandom_range(0, 2) == 0) begin a_idx.push_back(x); a_val.push_back($urandom); end
            if ($urandom_range(0, 2) == 0) begin b_idx.push_back(x); b_val.push_back($urandom); end
        end
        if (a_idx.size() == 0) begin a_idx.push_back(range); a_val.push_back($urandom); end
        if (b_idx.size() == 0) begin b_idx.push_back(range + 1); b_val.push_back($urandom); end
    endtask

    task automatic idle_inputs();
        start = 1'b0; out_stall = 1'b0;
        a_valid = 1'b0; a_index = '0; a_value = '0; a_last = 1'b0;
        b_valid = 1'b0; b_index = '0; b_value = '0; b_last = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({a_ready, b_ready, cas_valid1, cas_valid2, busy, done, err} !== 7'b0 ||
            cas_index1 !== '0 || cas_index2 !== '0 || cas_value1 !== '0 ||
            cas_value2 !== '0 || issue_cnt !== 16'd0 || match_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s: rdy=%b%b v=%b%b busy=%b done=%b err=%b idx=%0d/%0d cnt=%0d/%0d, required all zero",
                     tag, a_ready, b_ready, cas_valid1, cas_valid2, busy, done, err,
                     cas_index1, cas_index2, issue_cnt, match_cnt);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        out_stall = 1'b1;
        #1;
        checks++;
        if (cas_ena !== 1'b0) begin
            errors++; $display("FAIL reset_cas_ena: got %b required 0", cas_ena);
        end
        out_stall = 1'b0;
        #1;
        checks++;
        if (cas_ena !== 1'b1) begin
            errors++; $display("FAIL reset_cas_ena_hi: got %b required 1", cas_ena);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL start: busy=%b err=%b required busy=1 err=0", busy, err);
        end
    endtask

    task automatic run_merge(input string tag, input int stall_pct, input int drop_pct,
                             input int stall_at, input bit abort_flush, input bit exp_err);
        int ai = 0, bi = 0, k = 0, en = 0;
        int na = a_idx.size();
        int nb = b_idx.size();
        bit flushing = 1'b0, st, ar, br, finished = 1'b0;
        logic [2*ADDRW+2*WL+1:0] snap;
        build_expected();
        do_start();
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            st = ($urandom_range(0, 99) < stall_pct) || (cyc >= stall_at && cyc < stall_at + 3);
            out_stall = st;
            a_valid = (ai < na) && ($urandom_range(0, 99) >= drop_pct);
            a_index = (ai < na) ? ADDRW'(a_idx[ai]) : ADDRW'($urandom);
            a_value = (ai < na) ? a_val[ai] : $urandom;
            a_last  = (ai == na - 1);
            b_valid = (bi < nb) && ($urandom_range(0, 99) >= drop_pct);
            b_index = (bi < nb) ? ADDRW'(b_idx[bi]) : ADDRW'($urandom);
            b_value = (bi < nb) ? b_val[bi] : $urandom;
            b_last  = (bi == nb - 1);
            if (abort_flush && flushing && en == 2) rst = 1'b1;
            #1;
            checks++;
            if (cas_ena !== ~st) begin
                errors++; $display("FAIL %s_cas_ena: got %b required %b", tag, cas_ena, ~st);
            end
            if (st || bi >= nb || (!b_valid && ai < na)) begin
                checks++;
                if (a_ready !== 1'b0 && (st || !b_valid && bi < nb)) begin
                    errors++; $display("FAIL %s_a_ready_block: got %b required 0", tag, a_ready);
                end
            end
            if (st || ai >= na || (!a_valid && bi < nb)) begin
                checks++;
                if (b_ready !== 1'b0 && (st || !a_valid && ai < na)) begin
                    errors++; $display("FAIL %s_b_ready_block: got %b required 0", tag, b_ready);
                end
            end
            if (bi >= nb) begin
                checks++;
                if (b_ready !== 1'b0) begin
                    errors++; $display("FAIL %s_b_ready_after_done: got %b required 0", tag, b_ready);
                end
            end
            if (ai >= na) begin
                checks++;
                if (a_ready !== 1'b0) begin
                    errors++; $display("FAIL %s_a_ready_after_done: got %b required 0", tag, a_ready);
                end
            end
            ar = a_ready && a_valid;
            br = b_ready && b_valid;
            snap = {cas_valid1, cas_valid2, cas_index1, cas_index2, cas_value1, cas_value2};
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                idle_inputs();
                check_reset_outputs({tag, "_rst_flush"});
                for (int w = 0; w < PD + 2; w++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        errors++; $display("FAIL %s_no_done_after_rst: done=%b busy=%b required 0 0", tag, done, busy);
                    end
                end
                return;
            end
            if (ar) ai++;
            if (br) bi++;
            if (flushing && !st) en++;
            if (st) begin
                checks++;
                if ({cas_valid1, cas_valid2, cas_index1, cas_index2, cas_value1, cas_value2} !== snap) begin
                    errors++; $display("FAIL %s_stall_hold: cas outputs changed under stall", tag);
                end
            end else if (ar || br) begin
                checks++;
                if (k >= exp_q.size()) begin
                    errors++; $display("FAIL %s_extra_issue: got idx %0d required no issue", tag, cas_index1);
                end else if (cas_valid1 !== 1'b1 || cas_index1 !== ADDRW'(exp_q[k].i1) ||
                             cas_value1 !== exp_q[k].v1 || cas_valid2 !== exp_q[k].two ||
                             (exp_q[k].two && (cas_index2 !== ADDRW'(exp_q[k].i2) ||
                                               cas_value2 !== exp_q[k].v2))) begin
                    errors++;
                    $display("FAIL %s_issue%0d: got v=%b%b idx=%0d/%0d val=%h/%h required v=1%b idx=%0d/%0d val=%h/%h",
                             tag, k, cas_valid1, cas_valid2, cas_index1, cas_index2, cas_value1, cas_value2,
                             exp_q[k].two, exp_q[k].i1, exp_q[k].i2, exp_q[k].v1, exp_q[k].v2);
                end
                k++;
            end else begin
                checks++;
                if (cas_valid1 !== 1'b0 || cas_valid2 !== 1'b0) begin
                    errors++; $display("FAIL %s_bubble: valids %b%b required 00", tag, cas_valid1, cas_valid2);
                end
            end
            if (done) begin
                checks++;
                if (!flushing || en != PD || busy !== 1'b0) begin
                    errors++; $display("FAIL %s_done_timing: enabled cycles %0d busy=%b required %0d busy=0", tag, en, busy, PD);
                end
                finished = 1'b1;
            end
            if (k == exp_q.size() && !flushing) begin flushing = 1'b1; en = 0; end
        end
        idle_inputs();
        checks++;
        if (!finished) begin
            errors++; $display("FAIL %s_timeout: done not seen, required done", tag);
            return;
        end
        checks++;
        if (err !== exp_err) begin
            errors++; $display("FAIL %s_err: got %b required %b", tag, err, exp_err);
        end
        checks++;
`ifdef SPMERGE_STATS_EN
        if (issue_cnt !== 16'(exp_q.size()) || match_cnt !== 16'(exp_pairs)) begin
            errors++; $display("FAIL %s_stats: got %0d/%0d required %0d/%0d", tag, issue_cnt, match_cnt, exp_q.size(), exp_pairs);
        end
`else
        if (issue_cnt !== 16'd0 || match_cnt !== 16'd0) begin
            errors++; $display("FAIL %s_stats: got %0d/%0d required 0/0", tag, issue_cnt, match_cnt);
        end
`endif
    endtask

    task automatic set_streams(input int ai[$], input logic [31:0] av[$],
                               input int bi[$], input logic [31:0] bv[$]);
        a_idx = ai; a_val = av; b_idx = bi; b_val = bv;
    endtask

    task automatic test_basic();
        set_streams('{1, 4}, '{32'h3f800000, 32'h40000000},
                    '{2, 4}, '{32'h40400000, 32'h40a00000});
        run_merge("basic", 0, 0, 9999, 1'b0, 1'b0);
    endtask

    task automatic test_drain();
        set_streams('{0, 9}, '{32'h11111111, 32'h22222222}, '{3}, '{32'h33333333});
        run_merge("drain", 0, 0, 9999, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        gen_streams(12);
        run_merge("stall3", 0, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_drop();
        set_streams('{1, 8, 12}, '{32'h1, 32'h2, 32'h3}, '{2, 10}, '{32'h4, 32'h5});
        run_merge("drop", 0, 40, 9999, 1'b0, 1'b0);
    endtask

    task automatic test_order_err();
        set_streams('{5, 5}, '{32'hA, 32'hB}, '{7}, '{32'hC});
        run_merge("order_err", 0, 0, 9999, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b required 1", err);
        end
    endtask

    task automatic test_rst_flush();
        set_streams('{1, 3}, '{32'h5, 32'h6}, '{3}, '{32'h7});
        run_merge("rst_flush", 0, 0, 9999, 1'b1, 1'b0);
        gen_streams(10);
        run_merge("after_rst", 0, 0, 9999, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            gen_streams(40);
            run_merge($sformatf("rand%0d", r), 20, 20, 9999, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        gen_streams(20);
        run_merge("b2b_0", 0, 0, 9999, 1'b0, 1'b0);
        gen_streams(20);
        run_merge("b2b_1", 10, 0, 9999, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_drain();
        test_stall();
        test_drop();
        test_order_err();
        test_rst_flush();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
